// File: rtl/imem_arb_pkg.sv
// imem_arb_pkg: shared types for the I/D single-port memory arbiter.
// FSM states, owner encoding and the default watchdog limit.
package imem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

    localparam int DEF_TIMEOUT = 255;

endpackage

// File: rtl/imem_arbiter_if.sv
// Requester-side (I, D) and memory-side bundles for imem_arbiter.
// master = driver of the request, slave = the side that answers it.
interface imem_arb_ifetch_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    logic              req_valid;
    logic [ADDR_W-1:0] req_addr;
    logic              req_ready;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_data;
    logic              resp_err;

    modport master (
        output req_valid, req_addr,
        input  req_ready, resp_valid, resp_data, resp_err
    );
    modport slave (
        input  req_valid, req_addr,
        output req_ready, resp_valid, resp_data, resp_err
    );
endinterface

interface imem_arb_data_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    logic              req_valid;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              req_ready;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_data;
    logic              resp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_data, resp_err
    );
    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, resp_valid, resp_data, resp_err
    );
endinterface

interface imem_arb_mem_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    logic              req_valid;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              req_ready;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_data;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_data
    );
    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, resp_valid, resp_data
    );
endinterface

// File: rtl/imem_arb_sel.sv
// Winner select for imem_arbiter: round-robin when IMEM_ARB_RR_EN
// is defined, otherwise fixed D-over-I priority.
module imem_arb_sel
    import imem_arb_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic en_i,
    input  logic i_valid_i,
    input  logic d_valid_i,
    output logic gnt_i_o,
    output logic gnt_d_o
);

`ifdef IMEM_ARB_RR_EN
    owner_e last_q, last_d;
    logic   d_first;

    // On a tie the side that was not served last goes first.
    assign d_first = (last_q == OWN_I);
    assign gnt_d_o = en_i & d_valid_i & (~i_valid_i | d_first);
    assign gnt_i_o = en_i & i_valid_i & (~d_valid_i | ~d_first);

    always_comb begin
        last_d = last_q;
        if (gnt_d_o)
            last_d = OWN_D;
        else if (gnt_i_o)
            last_d = OWN_I;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            last_q <= OWN_I;
        else
            last_q <= last_d;
    end
`else
    logic unused_clk_rst;

    assign unused_clk_rst = clk ^ reset;
    assign gnt_d_o = en_i & d_valid_i;
    assign gnt_i_o = en_i & i_valid_i & ~d_valid_i;
`endif

endmodule

// File: rtl/imem_arbiter.sv
// imem_arbiter: one-outstanding I/D arbiter in front of a single-port
// memory with a response watchdog. IMEM_ARB_RR_EN selects round-robin.
module imem_arbiter
    import imem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                 clk,
    input  logic                 reset,
    imem_arb_ifetch_if.slave     i_bus,
    imem_arb_data_if.slave       d_bus,
    imem_arb_mem_if.master       mem_bus
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_e            state_q, state_d;
    owner_e            own_q, own_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    logic gnt_i, gnt_d, idle;
    logic i_rsp, d_rsp;
    logic unused_lsb;

    assign unused_lsb = ^{i_bus.req_addr[1:0], d_bus.req_addr[1:0]};

    // Readies are held off while reset is asserted.
    assign idle = (state_q == ST_IDLE) && reset;

    imem_arb_sel u_sel (
        .clk       (clk),
        .reset     (reset),
        .en_i      (idle),
        .i_valid_i (i_bus.req_valid),
        .d_valid_i (d_bus.req_valid),
        .gnt_i_o   (gnt_i),
        .gnt_d_o   (gnt_d)
    );

    always_comb begin
        state_d = state_q;
        own_d   = own_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (gnt_d) begin
                    own_d   = OWN_D;
                    wr_d    = d_bus.req_write;
                    addr_d  = {d_bus.req_addr[ADDR_W-1:2], 2'b00};
                    wdata_d = d_bus.req_wdata;
                    state_d = ST_ISSUE;
                end else if (gnt_i) begin
                    own_d   = OWN_I;
                    wr_d    = 1'b0;
                    addr_d  = {i_bus.req_addr[ADDR_W-1:2], 2'b00};
                    wdata_d = '0;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (mem_bus.req_ready) begin
                    cnt_d   = '0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A response in the last counted cycle still beats the watchdog.
                if (mem_bus.resp_valid) begin
                    rdata_d = wr_q ? '0 : mem_bus.resp_data;
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end else if (cnt_q >= CNT_LAST) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    cnt_d   = CNT_MAX;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            own_q   <= OWN_I;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            own_q   <= own_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign i_rsp = (state_q == ST_RESP) && (own_q == OWN_I);
    assign d_rsp = (state_q == ST_RESP) && (own_q == OWN_D);

    assign i_bus.req_ready  = gnt_i;
    assign i_bus.resp_valid = i_rsp;
    assign i_bus.resp_data  = i_rsp ? rdata_q : '0;
    assign i_bus.resp_err   = i_rsp & err_q;

    assign d_bus.req_ready  = gnt_d;
    assign d_bus.resp_valid = d_rsp;
    assign d_bus.resp_data  = d_rsp ? rdata_q : '0;
    assign d_bus.resp_err   = d_rsp & err_q;

    assign mem_bus.req_valid = (state_q == ST_ISSUE);
    assign mem_bus.req_write = wr_q;
    assign mem_bus.req_addr  = addr_q;
    assign mem_bus.req_wdata = wdata_q;

endmodule
